// File: rtl/add_share_sched.sv
// add_share_sched: round-robin time-sharing of one pipelined adder between
// N_REQ operand producers. Requester IDs ride a tag pipeline matched to the
// adder latency so every returned sum is labelled with its owner.
module add_share_sched #(
   parameter int N_REQ   = 4,
   parameter int ID_W    = 2,
   parameter int IN_W    = 12,
   parameter int OUT_W   = 13,
   parameter int ADD_LAT = 1
) (
   input  logic                    i_clk,
   input  logic                    i_rst,
   input  logic [N_REQ-1:0]        i_req_valid,
   input  logic [N_REQ*IN_W-1:0]   i_req_data_1,
   input  logic [N_REQ*IN_W-1:0]   i_req_data_2,
   output logic [N_REQ-1:0]        o_req_ready,
   output logic [IN_W-1:0]         o_add_data_1,
   output logic [IN_W-1:0]         o_add_data_2,
   input  logic [OUT_W-1:0]        i_add_result,
   output logic                    o_rsp_valid,
   output logic [ID_W-1:0]         o_rsp_id,
   output logic [OUT_W-1:0]        o_rsp_data,
   output logic                    o_busy,
   output logic [15:0]             o_issue_cnt
);

   // registered state
   logic [ID_W-1:0]                last_q, last_d;
   logic [ADD_LAT-1:0]             tag_vld_q, tag_vld_d;
   logic [ADD_LAT-1:0][ID_W-1:0]   tag_id_q, tag_id_d;
   logic                           rsp_valid_q, rsp_valid_d;
   logic [ID_W-1:0]                rsp_id_q, rsp_id_d;
   logic [OUT_W-1:0]               rsp_data_q, rsp_data_d;
   logic                           busy_q, busy_d;
   logic [15:0]                    issue_cnt_q, issue_cnt_d;

   // arbitration results
   logic                           grant_any;
   logic [ID_W-1:0]                grant_idx;
   logic [ID_W-1:0]                cand;

   // Round-robin search starting just after the last winner; nothing is granted in reset.
   always_comb begin
      grant_any = 1'b0;
      grant_idx = '0;
      cand      = '0;
      if (!i_rst) begin
         for (int off = 1; off <= N_REQ; off++) begin
            cand = ID_W'((int'(last_q) + off) % N_REQ);
            if (!grant_any && i_req_valid[cand]) begin
               grant_any = 1'b1;
               grant_idx = cand;
            end
         end
      end
   end

   // One-hot ready and operand mux; idle cycles feed zeros to the adder.
   always_comb begin
      o_req_ready  = '0;
      o_add_data_1 = '0;
      o_add_data_2 = '0;
      if (grant_any) begin
         o_req_ready  = N_REQ'(1) << grant_idx;
         o_add_data_1 = i_req_data_1[grant_idx*IN_W +: IN_W];
         o_add_data_2 = i_req_data_2[grant_idx*IN_W +: IN_W];
      end
   end

   // Next state: tag shift, response capture (ID/data hold on empty slots), busy, counter.
   always_comb begin
      tag_vld_d    = '0;
      tag_id_d     = '0;
      tag_vld_d[0] = grant_any;
      tag_id_d[0]  = grant_idx;
      for (int s = 1; s < ADD_LAT; s++) begin
         tag_vld_d[s] = tag_vld_q[s-1];
         tag_id_d[s]  = tag_id_q[s-1];
      end
      rsp_valid_d = tag_vld_q[ADD_LAT-1];
      rsp_id_d    = tag_vld_q[ADD_LAT-1] ? tag_id_q[ADD_LAT-1] : rsp_id_q;
      rsp_data_d  = tag_vld_q[ADD_LAT-1] ? i_add_result : rsp_data_q;
      busy_d      = |tag_vld_d;
      issue_cnt_d = issue_cnt_q + 16'(grant_any);
      last_d      = grant_any ? grant_idx : last_q;
   end

   // State update; reset drops everything in flight and re-arms requester 0 as first.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         last_q      <= ID_W'(N_REQ - 1);
         tag_vld_q   <= '0;
         tag_id_q    <= '0;
         rsp_valid_q <= 1'b0;
         rsp_id_q    <= '0;
         rsp_data_q  <= '0;
         busy_q      <= 1'b0;
         issue_cnt_q <= '0;
      end else begin
         last_q      <= last_d;
         tag_vld_q   <= tag_vld_d;
         tag_id_q    <= tag_id_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_id_q    <= rsp_id_d;
         rsp_data_q  <= rsp_data_d;
         busy_q      <= busy_d;
         issue_cnt_q <= issue_cnt_d;
      end
   end

   assign o_rsp_valid = rsp_valid_q;
   assign o_rsp_id    = rsp_id_q;
   assign o_rsp_data  = rsp_data_q;
   assign o_busy      = busy_q;
   assign o_issue_cnt = issue_cnt_q;

endmodule

// File: doc/add_share_sched.md
Name: add_share_sched

Overview:
- Time-shares one generated fixed-point adder (12-bit operands, 13-bit result, fixed pipeline delay) between N_REQ requesters.
- Each cycle it grants at most one requester by round-robin and drives that requester's operand pair into the adder.
- It tracks the requester ID through the adder's latency and returns each sum tagged with that ID.
- It sits between the per-channel operand producers and a single shared Add instance.

Parameters:
- N_REQ, 4, number of requesters (2..8).
- ID_W, 2, requester ID width; must equal ceil(log2(N_REQ)).
- IN_W, 12, operand width; matches the adder input width.
- OUT_W, 13, result width; matches the adder output width (IN_W+1).
- ADD_LAT, 1, adder latency in i_clk cycles (1..8); operands applied at cycle t produce a result at t+ADD_LAT.

Ports:
- i_clk  in  1  clock; all logic on rising edge.
- i_rst  in  1  synchronous reset, active-high.
- i_req_valid  in  N_REQ  per-requester operand pair valid.
- i_req_data_1  in  N_REQ*IN_W  packed operand 1; requester k occupies bits [k*IN_W +: IN_W].
- i_req_data_2  in  N_REQ*IN_W  packed operand 2; same packing.
- o_req_ready  out  N_REQ  one-hot (or zero) grant; a transfer occurs when valid&ready for requester k.
- o_add_data_1  out  IN_W  to adder i_data_1.
- o_add_data_2  out  IN_W  to adder i_data_2.
- i_add_result  in  OUT_W  from adder o_data.
- o_rsp_valid  out  1  result valid, one-cycle pulse per result.
- o_rsp_id  out  ID_W  requester that owns o_rsp_data.
- o_rsp_data  out  OUT_W  sum.
- o_busy  out  1  high while any issued pair has not yet been returned.
- o_issue_cnt  out  16  count of accepted pairs, wraps 0xFFFF->0.

Behaviour:
- Interface: one clock, i_clk; synchronous active-high reset, i_rst.
- Reset values: o_rsp_valid=0, o_rsp_id=0, o_rsp_data=0, o_busy=0, o_issue_cnt=0; round-robin pointer last=N_REQ-1, so requester 0 has top priority first; tag pipeline cleared.

Arbitration (combinational from i_req_valid and registered pointer last):
- Grant the first valid requester searching last+1, last+2, ..., wrapping modulo N_REQ.
- o_req_ready is the one-hot grant, all-zero when no valid.
- o_req_ready is forced to 0 while i_rst=1.
- On a grant, pointer last <= granted index at the next edge. With no grant, last holds.
- A requester dropping valid while un-granted is legal. Data is sampled only on the grant cycle.

Adder drive (combinational):
- o_add_data_1/2 = granted requester's operands; all zeros when no grant.
- Unused adder outputs from idle cycles must not produce responses.

Tag pipeline:
- ADD_LAT-deep shift register of {valid, id}.
- Stage 0 loads {grant_any, grant_idx} each edge.
- Stage ADD_LAT-1 aligns with i_add_result.

Response register:
- At each edge, o_rsp_valid <= tag_valid[ADD_LAT-1], o_rsp_id <= tag_id[ADD_LAT-1], o_rsp_data <= i_add_result.
- o_rsp_id and o_rsp_data update only when that tag is valid; otherwise they hold.
- Total latency is accept edge to o_rsp_valid = ADD_LAT+1 cycles.
- Responses cannot be back-pressured; the consumer must take every pulse.

Throughput, busy and counting:
- Throughput is one pair per cycle. Back-to-back grants to different or the same requester are allowed.
- o_busy = OR of all tag valids (registered, same timing as the tag pipeline).
- o_issue_cnt increments by 1 on each grant edge.

Boundary conditions:
- Reset mid-operation: all tags cleared at that edge, so in-flight sums are dropped and never reported. The pointer returns to N_REQ-1.
- Arithmetic saturation/wrap is owned by the adder; this block passes i_add_result unmodified.
- Single valid requester: it is granted every cycle.

Test Plan:
- Reset, then requester 2 only, pair (100, 23) -> o_req_ready=0b0100 that cycle; o_add_data_1=100, o_add_data_2=23; with ADD_LAT=1, o_rsp_valid at accept+2 with id=2, data=123; o_busy high for one cycle; o_issue_cnt=1.
- All four valid continuously for 8 cycles -> grant order 0,1,2,3,0,1,2,3; each returns the correct tagged sum; o_issue_cnt=8.
- Valid pattern 0b1001 after last grant 0 -> next grant 3, then 0, then 3. Requesters 1 and 2 are never granted.
- ADD_LAT=4, back-to-back issues id1 (5+6) then id3 (-7+2) -> responses on consecutive cycles: (1, 11) then (3, -5 as 13-bit 0x1FFB).
- Assert i_rst one cycle after issuing two pairs -> no o_rsp_valid pulses; o_busy=0 after reset; o_issue_cnt=0; next grant goes to requester 0.
- Preload traffic to 0xFFFF issues -> next accept wraps o_issue_cnt to 0; idle cycles produce no responses and zero adder operands.
